// File: rtl/bitstream_pkg.sv
// Shared types and sizing helpers for the stochastic bitstream decoder/encoder family.
package bitstream_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} decoder_state_t;

  // SKIP is limited to 0..255, so an 8-bit settle counter always suffices
  localparam int SETTLE_WIDTH = 8;

  function automatic int window_len(input int width);
    return 1 << width;
  endfunction

  function automatic int result_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/bitstream_decoder_window_counter.sv
// Wrapping up-counter with clear/enable; o_tc flags the cycle holding TC_VALUE.
module window_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TC_VALUE = '1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == TC_VALUE) ? '0 : r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/bitstream_decoder.sv
// Counts ones of a stochastic bitstream over 2^WIDTH cycles (after an optional
// settle phase) and hands the binary result out on a valid/ack handshake.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | discarding SKIP cycles while upstream pipelines flush
// COUNT  | sampling x on each of N cycles
// DONE   | result held on value/valid until ack
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SKIP    = 0,
  parameter bit BIPOLAR = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             x,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH+1:0] value
);

  localparam int N  = window_len(WIDTH);
  localparam int RW = result_width(WIDTH);
  localparam logic [SETTLE_WIDTH-1:0] SETTLE_TC =
    (SKIP > 0) ? SETTLE_WIDTH'(SKIP - 1) : '0;

  decoder_state_t r_state;
  decoder_state_t w_next;
  decoder_state_t w_launch;

  logic [WIDTH:0]  r_ones;
  logic [WIDTH:0]  w_ones_next;
  logic [RW-1:0]   r_value;
  logic [RW-1:0]   w_result;
  logic            w_in_count;
  logic            w_in_settle;
  logic            w_win_tc;
  logic            w_set_tc;

  assign w_in_count  = (r_state == COUNT);
  assign w_in_settle = (r_state == SETTLE);

  window_counter #(
    .WIDTH    (WIDTH),
    .TC_VALUE ({WIDTH{1'b1}})
  ) u_window (
    .clk   (clk),
    .n_rst (n_rst),
    .i_clr (!w_in_count),
    .i_en  (w_in_count),
    .o_tc  (w_win_tc)
  );

  window_counter #(
    .WIDTH    (SETTLE_WIDTH),
    .TC_VALUE (SETTLE_TC)
  ) u_settle (
    .clk   (clk),
    .n_rst (n_rst),
    .i_clr (!w_in_settle),
    .i_en  (w_in_settle),
    .o_tc  (w_set_tc)
  );

  always_comb begin
    w_launch = COUNT;
    if (SKIP > 0) begin
      w_launch = SETTLE;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_launch;
      SETTLE:  if (w_set_tc) w_next = COUNT;
      COUNT:   if (w_win_tc) w_next = DONE;
      DONE:    if (ack) w_next = start ? w_launch : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The latched result must include the final sample, so it is formed from the
  // incremented count rather than the registered one.
  assign w_ones_next = r_ones + {{WIDTH{1'b0}}, x};

  always_comb begin
    w_result = {1'b0, w_ones_next};
    if (BIPOLAR) begin
      w_result = {w_ones_next, 1'b0} - RW'(N);
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_ones <= '0;
    end else if (!w_in_count) begin
      r_ones <= '0;
    end else begin
      r_ones <= w_ones_next;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_value <= '0;
    end else if (w_in_count && w_win_tc) begin
      r_value <= w_result;
    end
  end

  assign busy  = w_in_count || w_in_settle;
  assign valid = (r_state == DONE);
  assign value = r_value;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed/randomized bench for bitstream_decoder across four parameter sets,
// checked against a window-counting reference model.
module tb_bitstream_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  logic       st [4];
  logic       xx [4];
  logic       ak [4];
  logic       bz [4];
  logic       vl [4];
  logic [5:0] v0, v1, v2;
  logic [9:0] v3;
  logic [9:0] last_val [4];

  int tests = 0;
  int fails = 0;

  bitstream_decoder #(.WIDTH(4), .SKIP(0), .BIPOLAR(1'b0)) u_d0 (
    .clk(clk), .n_rst(n_rst), .start(st[0]), .x(xx[0]), .ack(ak[0]),
    .busy(bz[0]), .valid(vl[0]), .value(v0));
  bitstream_decoder #(.WIDTH(4), .SKIP(0), .BIPOLAR(1'b1)) u_d1 (
    .clk(clk), .n_rst(n_rst), .start(st[1]), .x(xx[1]), .ack(ak[1]),
    .busy(bz[1]), .valid(vl[1]), .value(v1));
  bitstream_decoder #(.WIDTH(4), .SKIP(3), .BIPOLAR(1'b0)) u_d2 (
    .clk(clk), .n_rst(n_rst), .start(st[2]), .x(xx[2]), .ack(ak[2]),
    .busy(bz[2]), .valid(vl[2]), .value(v2));
  bitstream_decoder #(.WIDTH(8), .SKIP(0), .BIPOLAR(1'b0)) u_d3 (
    .clk(clk), .n_rst(n_rst), .start(st[3]), .x(xx[3]), .ack(ak[3]),
    .busy(bz[3]), .valid(vl[3]), .value(v3));

  function automatic int dw(input int i);
    return (i == 3) ? 8 : 4;
  endfunction

  function automatic int ds(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic bit db(input int i);
    return (i == 1);
  endfunction

  function automatic logic [9:0] dval(input int i);
    case (i)
      0:       return {4'b0, v0};
      1:       return {4'b0, v1};
      2:       return {4'b0, v2};
      default: return v3;
    endcase
  endfunction

  // Expected result: count of ones, or 2*count - N, truncated to WIDTH+2 bits
  function automatic logic [9:0] ref_value(input int cnt, input int i);
    int         n;
    int         r;
    logic [9:0] m;
    n = 1 << dw(i);
    r = db(i) ? (2 * cnt - n) : cnt;
    m = (10'd1 << (dw(i) + 2)) - 10'd1;
    return 10'(r) & m;
  endfunction

  // mode: 0 all zeros, 1 all ones, 2 alternating 1,0, 3 random with pct% ones,
  // 4 ones only in the first three cycles after start
  function automatic bit gen_x(input int mode, input int k, input int skip, input int pct);
    if (mode == 4) return (k <= 3);
    if (k <= skip) return 1'($urandom_range(1, 0));
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((k - skip - 1) % 2) == 0;
      default: return $urandom_range(99, 0) < pct;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input int i, input int mode, input int pct, input bit noise,
                         input bit started, input string tag);
    int n;
    int skip;
    int cnt;
    int bad;
    bit b;
    n    = 1 << dw(i);
    skip = ds(i);
    cnt  = 0;
    bad  = 0;
    if (!started) begin
      st[i] = 1'b1;
      xx[i] = 1'b1;
      tick();
      st[i] = 1'b0;
    end
    for (int k = 1; k <= skip + n; k++) begin
      b = gen_x(mode, k, skip, pct);
      xx[i] = b;
      if (k > skip && b) cnt++;
      if (noise) begin
        st[i] = 1'($urandom_range(1, 0));
        ak[i] = 1'($urandom_range(1, 0));
      end
      if (bz[i] !== 1'b1 || vl[i] !== 1'b0) bad++;
      tick();
    end
    st[i] = 1'b0;
    ak[i] = 1'b0;
    xx[i] = 1'b0;
    last_val[i] = ref_value(cnt, i);
    check({tag, " busy_window"}, bad, 0);
    check({tag, " valid"}, 32'(vl[i]), 1);
    check({tag, " busy_done"}, 32'(bz[i]), 0);
    check({tag, " value"}, 32'(dval(i)), 32'(last_val[i]));
  endtask

  task automatic finish(input int i, input int hold, input bit restart, input string tag);
    int bad;
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      st[i] = 1'($urandom_range(1, 0));
      xx[i] = 1'($urandom_range(1, 0));
      tick();
      if (vl[i] !== 1'b1 || bz[i] !== 1'b0 || dval(i) !== last_val[i]) bad++;
    end
    check({tag, " hold"}, bad, 0);
    ak[i] = 1'b1;
    st[i] = restart;
    tick();
    ak[i] = 1'b0;
    st[i] = 1'b0;
    check({tag, " valid_drop"}, 32'(vl[i]), 0);
    check({tag, " busy_after_ack"}, 32'(bz[i]), 32'(restart));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      xx[i] = 1'b0;
      ak[i] = 1'b0;
      last_val[i] = '0;
    end
    n_rst = 1'b1;
    st[0] = 1'b1;
    tick();
    tick();
    st[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset busy%0d", i), 32'(bz[i]), 0);
      check($sformatf("reset valid%0d", i), 32'(vl[i]), 0);
      check($sformatf("reset value%0d", i), 32'(dval(i)), 0);
    end
    n_rst = 1'b0;
    tick();

    // unipolar all ones, then a held result
    measure(0, 1, 0, 1'b0, 1'b0, "uni_ones");
    finish(0, 3, 1'b0, "uni_ones");

    // bipolar: half ones, all zeros, all ones, random
    measure(1, 2, 0, 1'b0, 1'b0, "bip_alt");
    finish(1, 1, 1'b0, "bip_alt");
    measure(1, 0, 0, 1'b0, 1'b0, "bip_zeros");
    finish(1, 1, 1'b0, "bip_zeros");
    measure(1, 1, 0, 1'b0, 1'b0, "bip_ones");
    finish(1, 1, 1'b0, "bip_ones");
    for (int r = 0; r < 4; r++) begin
      measure(1, 3, 50, 1'b0, 1'b0, "bip_rand");
      finish(1, 2, 1'b0, "bip_rand");
    end

    // settle discard, then random with settle noise
    measure(2, 4, 0, 1'b0, 1'b0, "settle_discard");
    finish(2, 1, 1'b0, "settle_discard");
    measure(2, 3, 40, 1'b0, 1'b0, "settle_rand");
    finish(2, 1, 1'b0, "settle_rand");

    // handshake: start ignored in DONE, then ack+start back-to-back
    measure(0, 3, 60, 1'b0, 1'b0, "hs_first");
    finish(0, 10, 1'b1, "hs_first");
    measure(0, 3, 30, 1'b0, 1'b1, "hs_second");
    finish(0, 1, 1'b0, "hs_second");

    // reset in the middle of the window
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      xx[0] = 1'b1;
      tick();
    end
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    check("midreset busy", 32'(bz[0]), 0);
    check("midreset valid", 32'(vl[0]), 0);
    check("midreset value", 32'(dval(0)), 0);
    tick();
    measure(0, 3, 50, 1'b0, 1'b0, "post_reset");
    finish(0, 1, 1'b0, "post_reset");

    // wide window, p=0.75, start/ack noise while counting
    measure(3, 3, 75, 1'b1, 1'b0, "wide_p75");
    finish(3, 2, 1'b0, "wide_p75");
    measure(3, 3, 75, 1'b1, 1'b0, "wide_p75b");
    finish(3, 1, 1'b0, "wide_p75b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitstream_decoder.md
Name: bitstream_decoder

Overview:
Converts a stochastic bitstream (e.g. the sigmoid output `y`) back into a binary value. It counts ones over a fixed window of 2^WIDTH clock cycles and presents the result on a valid/ack handshake. It sits at the network output boundary, the reader side of the bitstream encoding, and feeds binary results to the host/test logic. An optional settle phase discards the first cycles while upstream stochastic pipelines (exp/power/fraction chains) flush.

Parameters:
WIDTH, 8, log2 of the observation window; window length N = 2^WIDTH cycles
SKIP, 0, number of cycles discarded after start before counting begins (0..255)
BIPOLAR, 0, 0 = unipolar result (count); 1 = bipolar result (2*count - N)

Ports:
clk  input  1  system clock, all logic rising-edge
n_rst  input  1  synchronous, active-high reset (1 = reset); named per codebase convention, polarity fixed as stated
start  input  1  pulse; begins a measurement when the block is idle or done
x  input  1  stochastic bitstream input, sampled every clock while counting
ack  input  1  consumer accepts the current result
busy  output  1  high while in SETTLE or COUNT
valid  output  1  result available; held until ack
value  output  WIDTH+2  result; unsigned zero-extended count (BIPOLAR=0) or two's-complement 2*count-N (BIPOLAR=1)

Behaviour:
- Reset (n_rst=1 at a clk edge): state IDLE, busy=0, valid=0, value=0, internal counters=0. Reset has priority over every other input and aborts any measurement mid-window; no partial result is produced.
- States: IDLE, SETTLE, COUNT, DONE.
- IDLE: busy=0, valid=0. start=1 moves to SETTLE if SKIP>0, otherwise to COUNT. x is not sampled in the start cycle.
- SETTLE: x is ignored. The phase lasts exactly SKIP cycles, then moves to COUNT.
- COUNT: x is sampled on each of N consecutive cycles. The ones counter (WIDTH+1 bits) increments when x=1 and never wraps; the maximum is N. The window counter (WIDTH bits) wraps to 0 on the last sample. start is ignored in this state.
- COUNT to DONE: in the cycle after the last sample, valid=1, busy=0, and value is latched. The last sample is included in the latched count.
- Latency: with start asserted in cycle t, samples are taken in cycles t+1+SKIP through t+SKIP+N, and valid rises in cycle t+SKIP+N+1.
- DONE: value and valid are held stable until ack=1.
  - ack alone: valid drops next cycle and the state returns to IDLE.
  - ack and start together: valid drops next cycle and the block goes directly to SETTLE/COUNT. Back-to-back measurements have a 1-cycle gap.
  - start without ack: ignored. The result must not be lost.
- ack while valid=0 is ignored.
- Arithmetic:
  - Unipolar: value = {0, count}, range 0..N.
  - Bipolar: value = (count << 1) - N in WIDTH+2-bit signed, range -N..+N. All-zeros gives -N; all-ones gives +N; exactly half ones gives 0.
- The counters are cleared on entry to COUNT, so no stale count carries into the next measurement.

Decomposition:
- Shared package `bitstream_pkg`:
  - decoder_state_t enum {IDLE, SETTLE, COUNT, DONE}
  - a localparam/function for window length N from WIDTH
  - the result width WIDTH+2
  - These are reusable by a future bitstream_encoder (SNG).
- One sub-module, `window_counter`:
  - parameterised WIDTH-bit counter with clear, enable and a terminal-count flag
  - instantiated once for the window and once, WIDTH-parameterised, for SETTLE
  - the ones accumulator stays inline.

Test Plan:
1. WIDTH=4, SKIP=0, BIPOLAR=0, x constantly 1, start pulse at cycle 0 -> busy during cycles 1–16, valid=1 at cycle 17, value=16, held until ack.
2. WIDTH=4, BIPOLAR=1, x alternating 1,0 -> value=0. Repeat with x=0 -> value=-16 (0x30 in 6 bits). Repeat with x=1 -> value=+16.
3. WIDTH=4, SKIP=3, x=1 only during the first 3 cycles after start, then 0 -> value=0. Verifies settle discard and valid at cycle 20.
4. Handshake: in DONE, hold ack=0 for 10 cycles while pulsing start -> value/valid unchanged. Then assert ack and start together -> valid low next cycle, new measurement completes N+1 cycles after that.
5. Reset mid-window: assert n_rst=1 at cycle 8 of COUNT -> next cycle busy=0, valid=0, value=0. A following start yields a fresh, correct count with no residue.
6. Drive x from a known p=0.75 LFSR stream, WIDTH=8, unipolar -> value within ±16 of 192. start and ack pulses during COUNT have no effect.
